cmd_stream_arbiter: RTL and testbench
=====================================

// Module: cmd_stream_arbiter
// PURPOSE
//   Packet-atomic round-robin arbiter that shares the single 128-bit command AXI-Stream input of sddt_core
//   between NUM_REQ requesters (e.g. host DMA, refresh/ZQ generator, test engine). Runs in the axi_aclk
//   domain ahead of the async command FIFO. Never interleaves beats of different packets, because the FIFO
//   is in packet mode and the scheduler consumes whole tlast-terminated command packets.
// PARAMETERS
//   NUM_REQ    4    number of requester streams, 2..8
//   CMD_WIDTH  128  command beat width, in bits
//   IDX_WIDTH  (localparam) $clog2(NUM_REQ); width of grant index
// PORTS
//   axi_aclk            in   1                  single clock
//   axi_aresetn         in   1                  synchronous, active-low reset
//   s_axis_cmd_tdata    in   NUM_REQ*CMD_WIDTH  requester i occupies bits [i*CMD_WIDTH +: CMD_WIDTH]
//   s_axis_cmd_tvalid   in   NUM_REQ            per-requester valid
//   s_axis_cmd_tlast    in   NUM_REQ            per-requester end of packet
//   s_axis_cmd_tready   out  NUM_REQ            per-requester ready; only the granted bit may be 1
//   m_axis_cmd_tdata    out  CMD_WIDTH          to S_AXIS_CMD_tdata
//   m_axis_cmd_tvalid   out  1                  to S_AXIS_CMD_tvalid
//   m_axis_cmd_tlast    out  1                  to S_AXIS_CMD_tlast
//   m_axis_cmd_tready   in   1                  from S_AXIS_CMD_tready
//   req_enable          in   NUM_REQ            1 = requester eligible for arbitration
//   grant_idx           out  IDX_WIDTH          current or most recent grantee
//   busy                out  1                  1 while in XFER or while the output stage holds data
// BEHAVIOUR
//   - Reset (axi_aresetn=0 at a clock edge):
//     - state=IDLE; s_axis_cmd_tready=0; m_axis_cmd_tvalid=0; m_axis_cmd_tlast=0; grant_idx=0; busy=0.
//     - last_grant=NUM_REQ-1, so requester 0 wins first. Skid buffer emptied. Reset mid-packet discards the
//       partial packet; no recovery or tlast insertion is made.
//   - FSM IDLE:
//     - eligible = s_axis_cmd_tvalid & req_enable.
//     - If eligible!=0, pick the first set bit searching from last_grant+1 upward, wrapping modulo NUM_REQ.
//       Register that index to grant_idx, go to XFER. All tready stay 0 in IDLE.
//     - If eligible==0, stay in IDLE.
//   - FSM XFER:
//     - s_axis_cmd_tready[grant_idx] = skid-buffer input ready; all other tready bits = 0.
//     - A beat is accepted when tvalid & tready of the grantee are both 1.
//     - On an accepted beat with tlast=1: last_grant<=grant_idx, go to IDLE.
//     - The grant is held until tlast regardless of req_enable changes or grantee tvalid gaps.
//   - Bubble: exactly 1 idle cycle between packets (the arbitration cycle). Sustained in-packet throughput is
//     1 beat/clk.
//   - Output stage: 2-entry skid buffer; all m_axis outputs are registered.
//     - Latency from accepted input beat to m_axis_cmd_tvalid is 1 cycle.
//     - m_axis data and tlast are held stable while tvalid=1 and tready=0.
//     - Input-side ready is registered: it is 1 while the buffer has at least one free entry at clock start.
//   - Simultaneous events: FSM returns to IDLE on tlast even while the output stage still holds beats. The next
//     grant may start immediately; ordering is preserved by the FIFO nature of the buffer.
//   - Single-beat packet (tvalid and tlast in the first beat) costs IDLE+XFER = 2 cycles.
//   - busy = (state==XFER) | skid-buffer non-empty.
// CONFIGURATION
//   - CMD_ARB_STATS_EN defined:
//     - Adds output port grant_count [NUM_REQ*32], one saturating 32-bit packet counter per requester.
//     - A counter increments when its requester's tlast beat is accepted, and holds at 32'hFFFF_FFFF.
//     - Counters clear on reset.
//     - The debug/state path can read the counters.
//   - CMD_ARB_STATS_EN undefined: the port and the counters are absent; behaviour is otherwise identical.
// STRUCTURE
//   - Shared package sddt_pkg:
//     - localparam CMD_WIDTH=128.
//     - Arbiter FSM state encoding: ARB_IDLE=1'b0, ARB_XFER=1'b1.
//     - Function rr_next(eligible, last) returning the round-robin index.
//   - Sub-module axis_skid_buf (parameter WIDTH=CMD_WIDTH+1, data plus tlast): the 2-entry registered
//     output stage.
//   - The top level holds the FSM, the round-robin pointer, the input mux and the optional counters.
// TESTING
//   - Reset release with req0 and req2 both valid (1-beat packets, tdata 0xA0 and 0xA2):
//     - m_axis emits 0xA0, then 0xA2.
//     - grant_idx sequence is 0 then 2.
//   - req1 sends a 3-beat packet (0x11,0x12,0x13+tlast) while req0 is valid after beat 1:
//     - m_axis sees 0x11,0x12,0x13 contiguous with no req0 interleave.
//     - req0 is granted next.
//   - All 4 requesters continuously valid, 1-beat packets, m_tready=1:
//     - grant order is 0,1,2,3,0,1,...
//     - a new beat appears every 2 clocks.
//   - m_axis_cmd_tready=0 for 5 cycles mid-packet:
//     - m_tdata and m_tlast are stable throughout.
//     - at most 2 beats are accepted from the grantee; no beat is lost or duplicated after tready=1.
//   - req_enable=4'b1101 with all valid:
//     - req1 is never granted.
//     - req_enable cleared for the grantee mid-packet still completes the packet.
//   - axi_aresetn=0 for 1 cycle mid-packet:
//     - next cycle all tready=0, m_tvalid=0, grant_idx=0.
//     - with CMD_ARB_STATS_EN, grant_count reads 0.

Source files
------------

// File: rtl/sddt_pkg.sv
// rtl/sddt_pkg.sv - shared command-path constants, arbiter state encoding and round-robin helper
package sddt_pkg;

  localparam int CMD_WIDTH = 128;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_e;

  // Search upward from last+1, wrapping at n; supports up to 8 requesters.
  function automatic logic [2:0] rr_next(input logic [7:0] eligible, input logic [2:0] last,
                                         input int unsigned n);
    logic [2:0]  w_pick;
    logic        w_found;
    int unsigned w_idx;
    w_pick  = last;
    w_found = 1'b0;
    for (int unsigned i = 1; i <= 8; i++) begin
      w_idx = (32'(last) + i) % n;
      if (!w_found && i <= n && eligible[w_idx[2:0]]) begin
        w_pick  = w_idx[2:0];
        w_found = 1'b1;
      end
    end
    return w_pick;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// rtl/axis_skid_buf.sv - 2-entry registered output stage; input ready and all outputs come from flops
module axis_skid_buf #(
  parameter int WIDTH = sddt_pkg::CMD_WIDTH + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tvalid,
  output logic             o_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tvalid,
  input  logic             i_tready
);

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [1:0]       r_cnt;
  logic             r_out_valid;
  logic             r_in_ready;
  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_cnt_nxt;

  always_comb begin
    w_push    = i_tvalid & r_in_ready;
    w_pop     = r_out_valid & i_tready;
    w_cnt_nxt = r_cnt;
    case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + 2'd1;
      2'b01:   w_cnt_nxt = r_cnt - 2'd1;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_cnt       <= 2'd0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_out_valid <= (w_cnt_nxt != 2'd0);
      r_in_ready  <= (w_cnt_nxt != 2'd2);
      // Head always presents the oldest beat; tail is only used while full.
      if (w_pop) begin
        if (r_cnt == 2'd2)
          r_head <= r_tail;
        else if (w_push)
          r_head <= i_tdata;
      end else if (w_push) begin
        if (r_cnt == 2'd0)
          r_head <= i_tdata;
        else
          r_tail <= i_tdata;
      end
    end
  end

  assign o_tready = r_in_ready;
  assign o_tdata  = r_head;
  assign o_tvalid = r_out_valid;

endmodule

// File: rtl/cmd_stream_arbiter.sv
// rtl/cmd_stream_arbiter.sv - packet-atomic round-robin command stream arbiter
// Optional per-requester packet counters on grant_count when CMD_ARB_STATS_EN is defined.
module cmd_stream_arbiter #(
  parameter  int NUM_REQ   = 4,
  parameter  int CMD_WIDTH = sddt_pkg::CMD_WIDTH,
  localparam int IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                         axi_aclk,
  input  logic                         axi_aresetn,
  input  logic [NUM_REQ*CMD_WIDTH-1:0] s_axis_cmd_tdata,
  input  logic [NUM_REQ-1:0]           s_axis_cmd_tvalid,
  input  logic [NUM_REQ-1:0]           s_axis_cmd_tlast,
  output logic [NUM_REQ-1:0]           s_axis_cmd_tready,
  output logic [CMD_WIDTH-1:0]         m_axis_cmd_tdata,
  output logic                         m_axis_cmd_tvalid,
  output logic                         m_axis_cmd_tlast,
  input  logic                         m_axis_cmd_tready,
  input  logic [NUM_REQ-1:0]           req_enable,
  output logic [IDX_WIDTH-1:0]         grant_idx,
  output logic                         busy
`ifdef CMD_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]        grant_count
`endif
);

  import sddt_pkg::*;

  arb_state_e           r_state;
  logic [IDX_WIDTH-1:0] r_grant;
  logic [IDX_WIDTH-1:0] r_last_grant;
  logic [NUM_REQ-1:0]   w_elig;
  logic [IDX_WIDTH-1:0] w_next;
  logic [CMD_WIDTH-1:0] w_sel_data;
  logic                 w_sel_valid;
  logic                 w_sel_last;
  logic                 w_buf_ready;
  logic                 w_accept;

  assign w_elig      = s_axis_cmd_tvalid & req_enable;
  assign w_next      = IDX_WIDTH'(rr_next(8'(w_elig), 3'(r_last_grant), NUM_REQ));
  assign w_sel_data  = s_axis_cmd_tdata[r_grant*CMD_WIDTH +: CMD_WIDTH];
  assign w_sel_valid = (r_state == ARB_XFER) & s_axis_cmd_tvalid[r_grant];
  assign w_sel_last  = s_axis_cmd_tlast[r_grant];
  assign w_accept    = w_sel_valid & w_buf_ready;

  always_comb begin
    s_axis_cmd_tready = '0;
    if (r_state == ARB_XFER)
      s_axis_cmd_tready[r_grant] = w_buf_ready;
  end

  // The grant is released only by an accepted tlast beat, so packets never interleave.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      r_state      <= ARB_IDLE;
      r_grant      <= '0;
      r_last_grant <= IDX_WIDTH'(NUM_REQ - 1);
    end else if (r_state == ARB_IDLE) begin
      if (|w_elig) begin
        r_grant <= w_next;
        r_state <= ARB_XFER;
      end
    end else if (w_accept && w_sel_last) begin
      r_last_grant <= r_grant;
      r_state      <= ARB_IDLE;
    end
  end

  axis_skid_buf #(
    .WIDTH(CMD_WIDTH + 1)
  ) u_skid (
    .clk      (axi_aclk),
    .resetn   (axi_aresetn),
    .i_tdata  ({w_sel_last, w_sel_data}),
    .i_tvalid (w_sel_valid),
    .o_tready (w_buf_ready),
    .o_tdata  ({m_axis_cmd_tlast, m_axis_cmd_tdata}),
    .o_tvalid (m_axis_cmd_tvalid),
    .i_tready (m_axis_cmd_tready)
  );

  assign grant_idx = r_grant;
  assign busy      = (r_state == ARB_XFER) | m_axis_cmd_tvalid;

`ifdef CMD_ARB_STATS_EN
  logic [31:0] r_grant_count [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
    always_ff @(posedge axi_aclk) begin
      if (!axi_aresetn)
        r_grant_count[g] <= '0;
      else if (w_accept && w_sel_last && r_grant == IDX_WIDTH'(g) &&
               r_grant_count[g] != 32'hFFFF_FFFF)
        r_grant_count[g] <= r_grant_count[g] + 32'd1;
    end
    assign grant_count[g*32 +: 32] = r_grant_count[g];
  end
`endif

endmodule

// File: tb/tb_cmd_stream_arbiter.sv
// tb/tb_cmd_stream_arbiter.sv - directed self-checking bench for cmd_stream_arbiter
module tb_cmd_stream_arbiter;

  localparam int NR = 4;
  localparam int CW = 128;

  logic             clk = 1'b0;
  logic             rstn;
  logic [NR*CW-1:0] s_tdata  = '0;
  logic [NR-1:0]    s_tvalid = '0;
  logic [NR-1:0]    s_tlast  = '0;
  logic [NR-1:0]    s_tready;
  logic [CW-1:0]    m_tdata;
  logic             m_tvalid;
  logic             m_tlast;
  logic             m_tready;
  logic [NR-1:0]    req_enable;
  logic [1:0]       grant_idx;
  logic             busy;
`ifdef CMD_ARB_STATS_EN
  logic [NR*32-1:0] grant_count;
`endif

  always #5 clk = ~clk;

  cmd_stream_arbiter #(.NUM_REQ(NR), .CMD_WIDTH(CW)) dut (
    .axi_aclk          (clk),
    .axi_aresetn       (rstn),
    .s_axis_cmd_tdata  (s_tdata),
    .s_axis_cmd_tvalid (s_tvalid),
    .s_axis_cmd_tlast  (s_tlast),
    .s_axis_cmd_tready (s_tready),
    .m_axis_cmd_tdata  (m_tdata),
    .m_axis_cmd_tvalid (m_tvalid),
    .m_axis_cmd_tlast  (m_tlast),
    .m_axis_cmd_tready (m_tready),
    .req_enable        (req_enable),
    .grant_idx         (grant_idx),
    .busy              (busy)
`ifdef CMD_ARB_STATS_EN
    ,
    .grant_count       (grant_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int in_beats = 0;
  logic          flush;
  logic [NR-1:0] acc = '0;
  logic [CW:0]   src_mem [NR][16];
  int            wr_ptr  [NR] = '{default: 0};
  int            rd_ptr  [NR] = '{default: 0};
  logic [CW:0]   out_q[$];
  int            out_cyc[$];
  int            done_q[$];

  always @(posedge clk) cyc++;

  // Requester sources: hold each beat until it is seen accepted.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NR; i++) begin
      if (flush) rd_ptr[i] = wr_ptr[i];
      else if (acc[i]) rd_ptr[i] = rd_ptr[i] + 1;
      if (rd_ptr[i] != wr_ptr[i]) begin
        s_tvalid[i] = 1'b1;
        {s_tlast[i], s_tdata[i*CW +: CW]} = src_mem[i][rd_ptr[i] % 16];
      end else begin
        s_tvalid[i] = 1'b0;
        s_tlast[i]  = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) begin
      acc[i] = rstn && s_tvalid[i] && s_tready[i];
      if (acc[i]) begin
        in_beats++;
        if (s_tlast[i]) done_q.push_back(i);
      end
    end
    if (rstn && m_tvalid && m_tready) begin
      out_q.push_back({m_tlast, m_tdata});
      out_cyc.push_back(cyc);
    end
  end

  task automatic push(input int i, input logic last, input logic [CW-1:0] d);
    src_mem[i][wr_ptr[i] % 16] = {last, d};
    wr_ptr[i] = wr_ptr[i] + 1;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rstn = 1'b0; flush = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0; rstn = 1'b1;
  endtask

  task automatic test_reset();
    int ob;
    push(0, 1'b1, 128'hA0);
    push(2, 1'b1, 128'hA2);
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (s_tready !== 4'b0000) begin n_fail++; $display("FAIL rst_tready: got %b exp 0000", s_tready); end
    n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_m_tvalid: got %b exp 0", m_tvalid); end
    n_checks++; if (m_tlast !== 1'b0) begin n_fail++; $display("FAIL rst_m_tlast: got %b exp 0", m_tlast); end
    n_checks++; if (grant_idx !== 2'd0) begin n_fail++; $display("FAIL rst_grant_idx: got %0d exp 0", grant_idx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", busy); end
    ob = out_q.size();
    #1 rstn = 1'b1;
    for (int c = 0; c < 50 && out_q.size() < ob + 2; c++) @(negedge clk);
    n_checks++; if (out_q.size() !== ob + 2) begin n_fail++; $display("FAIL rel_count: got %0d exp %0d", out_q.size(), ob + 2); end
    n_checks++; if (out_q[ob] !== {1'b1, 128'hA0}) begin n_fail++; $display("FAIL rel_beat0: got %h exp 1_a0", out_q[ob]); end
    n_checks++; if (out_q[ob+1] !== {1'b1, 128'hA2}) begin n_fail++; $display("FAIL rel_beat1: got %h exp 1_a2", out_q[ob+1]); end
    n_checks++; if (done_q[0] !== 0) begin n_fail++; $display("FAIL rel_grant0: got %0d exp 0", done_q[0]); end
    n_checks++; if (done_q[1] !== 2) begin n_fail++; $display("FAIL rel_grant1: got %0d exp 2", done_q[1]); end
    n_checks++; if (out_cyc[ob+1] - out_cyc[ob] !== 2) begin n_fail++; $display("FAIL rel_spacing: got %0d exp 2", out_cyc[ob+1] - out_cyc[ob]); end
  endtask

  task automatic test_no_interleave();
    int ob, db;
    logic [CW:0] exp_o [4];
    exp_o[0] = {1'b0, 128'h11}; exp_o[1] = {1'b0, 128'h12};
    exp_o[2] = {1'b1, 128'h13}; exp_o[3] = {1'b1, 128'h01};
    ob = out_q.size(); db = done_q.size();
    push(1, 1'b0, 128'h11); push(1, 1'b0, 128'h12); push(1, 1'b1, 128'h13);
    repeat (3) @(posedge clk);
    #2 push(0, 1'b1, 128'h01);
    for (int c = 0; c < 60 && out_q.size() < ob + 4; c++) @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      n_checks++; if (out_q[ob+j] !== exp_o[j]) begin n_fail++; $display("FAIL ni_beat%0d: got %h exp %h", j, out_q[ob+j], exp_o[j]); end
    end
    n_checks++; if (out_cyc[ob+2] - out_cyc[ob] !== 2) begin n_fail++; $display("FAIL ni_contiguous: got %0d exp 2", out_cyc[ob+2] - out_cyc[ob]); end
    n_checks++; if (done_q[db] !== 1) begin n_fail++; $display("FAIL ni_first_grant: got %0d exp 1", done_q[db]); end
    n_checks++; if (done_q[db+1] !== 0) begin n_fail++; $display("FAIL ni_next_grant: got %0d exp 0", done_q[db+1]); end
  endtask

  task automatic test_round_robin();
    int ob, db;
    do_reset();
    ob = out_q.size(); db = done_q.size();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NR; i++) push(i, 1'b1, 128'(16 * k + i));
    for (int c = 0; c < 100 && out_q.size() < ob + 8; c++) @(negedge clk);
    for (int j = 0; j < 8; j++) begin
      n_checks++; if (done_q[db+j] !== j % 4) begin n_fail++; $display("FAIL rr_order%0d: got %0d exp %0d", j, done_q[db+j], j % 4); end
      n_checks++; if (out_q[ob+j] !== {1'b1, 128'(16 * (j / 4) + j % 4)}) begin n_fail++; $display("FAIL rr_data%0d: got %h exp %0d", j, out_q[ob+j], 16 * (j / 4) + j % 4); end
      if (j > 0) begin
        n_checks++; if (out_cyc[ob+j] - out_cyc[ob+j-1] !== 2) begin n_fail++; $display("FAIL rr_rate%0d: got %0d exp 2", j, out_cyc[ob+j] - out_cyc[ob+j-1]); end
      end
    end
  endtask

  task automatic test_backpressure();
    int ob, ib;
    ob = out_q.size();
    push(2, 1'b0, 128'h41); push(2, 1'b0, 128'h42); push(2, 1'b0, 128'h43); push(2, 1'b1, 128'h44);
    for (int c = 0; c < 50 && !m_tvalid; c++) @(negedge clk);
    @(posedge clk); #2;
    m_tready = 1'b0;
    ib = in_beats;
    repeat (5) begin
      @(negedge clk);
      n_checks++; if (m_tdata !== 128'h42) begin n_fail++; $display("FAIL bp_hold_data: got %h exp 42", m_tdata); end
      n_checks++; if ({m_tvalid, m_tlast} !== 2'b10) begin n_fail++; $display("FAIL bp_hold_ctl: got %b exp 10", {m_tvalid, m_tlast}); end
    end
    @(posedge clk); #2;
    m_tready = 1'b1;
    n_checks++; if (in_beats - ib > 2) begin n_fail++; $display("FAIL bp_accepted: got %0d exp <=2", in_beats - ib); end
    for (int c = 0; c < 50 && out_q.size() < ob + 4; c++) @(negedge clk);
    repeat (4) @(negedge clk);
    n_checks++; if (out_q.size() !== ob + 4) begin n_fail++; $display("FAIL bp_count: got %0d exp %0d", out_q.size(), ob + 4); end
    for (int j = 0; j < 4; j++) begin
      n_checks++; if (out_q[ob+j] !== {(j == 3), 128'(8'h41 + j)}) begin n_fail++; $display("FAIL bp_beat%0d: got %h exp %0d_%h", j, out_q[ob+j], (j == 3), 8'h41 + j); end
    end
  endtask

  task automatic test_req_enable();
    int ob, db, ib;
    int order [6];
    order = '{0, 2, 3, 0, 2, 3};
    do_reset();
    req_enable = 4'b1101;
    ob = out_q.size(); db = done_q.size();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NR; i++) push(i, 1'b1, 128'(8'h50 + 16 * k + i));
    for (int c = 0; c < 100 && out_q.size() < ob + 6; c++) @(negedge clk);
    repeat (10) @(negedge clk);
    n_checks++; if (done_q.size() !== db + 6) begin n_fail++; $display("FAIL en_packets: got %0d exp %0d", done_q.size() - db, 6); end
    for (int j = 0; j < 6; j++) begin
      n_checks++; if (done_q[db+j] !== order[j]) begin n_fail++; $display("FAIL en_order%0d: got %0d exp %0d", j, done_q[db+j], order[j]); end
      n_checks++; if (out_q[ob+j] !== {1'b1, 128'(8'h50 + 16 * (j / 3) + order[j])}) begin n_fail++; $display("FAIL en_data%0d: got %h", j, out_q[ob+j]); end
    end
    do_reset();
    req_enable = 4'b1000;
    ib = in_beats; ob = out_q.size(); db = done_q.size();
    push(3, 1'b0, 128'h71); push(3, 1'b0, 128'h72); push(3, 1'b1, 128'h73);
    for (int c = 0; c < 50 && in_beats < ib + 1; c++) @(negedge clk);
    @(posedge clk); #2;
    req_enable = 4'b0000;
    for (int c = 0; c < 50 && out_q.size() < ob + 3; c++) @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      n_checks++; if (out_q[ob+j] !== {(j == 2), 128'(8'h71 + j)}) begin n_fail++; $display("FAIL en_mid_beat%0d: got %h exp %0d_%h", j, out_q[ob+j], (j == 2), 8'h71 + j); end
    end
    n_checks++; if (done_q[db] !== 3) begin n_fail++; $display("FAIL en_mid_grant: got %0d exp 3", done_q[db]); end
    req_enable = 4'b1111;
  endtask

  task automatic test_reset_mid();
    int ib;
    ib = in_beats;
    push(2, 1'b0, 128'h81); push(2, 1'b0, 128'h82); push(2, 1'b0, 128'h83); push(2, 1'b1, 128'h84);
    for (int c = 0; c < 50 && in_beats < ib + 2; c++) @(negedge clk);
    @(posedge clk); #2;
    n_checks++; if (grant_idx !== 2'd2) begin n_fail++; $display("FAIL rm_pre_grant: got %0d exp 2", grant_idx); end
    rstn = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (s_tready !== 4'b0000) begin n_fail++; $display("FAIL rm_tready: got %b exp 0000", s_tready); end
    n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rm_m_tvalid: got %b exp 0", m_tvalid); end
    n_checks++; if (grant_idx !== 2'd0) begin n_fail++; $display("FAIL rm_grant_idx: got %0d exp 0", grant_idx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b exp 0", busy); end
`ifdef CMD_ARB_STATS_EN
    n_checks++; if (grant_count !== '0) begin n_fail++; $display("FAIL rm_grant_count: got %h exp 0", grant_count); end
`endif
    #1;
    flush = 1'b0; rstn = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if ({m_tvalid, busy} !== 2'b00) begin n_fail++; $display("FAIL rm_after: got %b exp 00", {m_tvalid, busy}); end
  endtask

  initial begin
    rstn       = 1'b0;
    flush      = 1'b0;
    m_tready   = 1'b1;
    req_enable = 4'b1111;
    test_reset();
    test_no_interleave();
    test_round_robin();
    test_backpressure();
    test_req_enable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
